// File: rtl/ifu_pkg.sv
// Shared constants and the decoded view of the fetch-to-decode bus.
package ifu_pkg;

    localparam logic [5:0] ECODE_ADEF    = 6'h08;
    localparam logic [8:0] ESUBCODE_NONE = 9'h0;

    localparam int IF_ADDR_W = 32;
    localparam int IF_BUS_W  = 32 + IF_ADDR_W + 1 + 6 + 9 + IF_ADDR_W;

    typedef struct packed {
        logic [31:0]          inst;
        logic [IF_ADDR_W-1:0] pc;
        logic                 exc_en;
        logic [5:0]           ecode;
        logic [8:0]           esubcode;
        logic [IF_ADDR_W-1:0] badv;
    } if_bus_t;

endpackage

// File: rtl/ifu_entry_queue.sv
// In-order instruction queue: entries are allocated at issue, filled by
// in-order responses, and popped at the head once done.
module ifu_entry_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic                         alloc,
    input  logic [ADDR_W-1:0]            alloc_pc,
    input  logic                         alloc_exc,
    input  logic [5:0]                   alloc_ecode,
    input  logic                         fill,
    input  logic [31:0]                  fill_inst,
    input  logic                         pop,
    output logic                         head_done,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [31:0]                  head_inst,
    output logic                         head_exc,
    output logic [5:0]                   head_ecode,
    output logic [$clog2(DEPTH+1)-1:0]   live_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [31:0]       inst_q  [DEPTH];
    logic [5:0]        ecode_q [DEPTH];
    logic [DEPTH-1:0]  exc_q;
    logic [DEPTH-1:0]  done_q;
    logic [PW-1:0]     alloc_ptr, fill_ptr, head_ptr;

    // NOTE: payload storage has no reset; done_q alone says which entries hold valid data.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_q[alloc_ptr]    <= alloc_pc;
            exc_q[alloc_ptr]   <= alloc_exc;
            ecode_q[alloc_ptr] <= alloc_ecode;
            if (alloc_exc)
                inst_q[alloc_ptr] <= '0;
        end
        if (fill)
            inst_q[fill_ptr] <= fill_inst;
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            done_q    <= '0;
            live_cnt  <= '0;
        end else begin
            if (alloc) begin
                done_q[alloc_ptr] <= alloc_exc;
                alloc_ptr         <= alloc_ptr + 1'b1;
            end
            if (fill) begin
                done_q[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + 1'b1;
            end
            if (pop) begin
                done_q[head_ptr] <= 1'b0;
                head_ptr         <= head_ptr + 1'b1;
            end
            live_cnt <= live_cnt + CW'(alloc) - CW'(pop);
        end
    end

    assign head_done  = done_q[head_ptr];
    assign head_pc    = pc_q[head_ptr];
    assign head_inst  = inst_q[head_ptr];
    assign head_exc   = exc_q[head_ptr];
    assign head_ecode = ecode_q[head_ptr];

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Fetch front end: PC generation, multi-outstanding issue, stale-response
// discard after redirects, and fetch-exception insertion.
module ifu_prefetch_queue
    import ifu_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h1c000000
) (
    input  logic                          clk,
    input  logic                          resetn,
    output logic                          inst_req,
    output logic [ADDR_W-1:0]             inst_addr,
    input  logic                          inst_addr_ok,
    input  logic                          inst_data_ok,
    input  logic [31:0]                   inst_rdata,
    output logic [ADDR_W-1:0]             xlat_va,
    input  logic [ADDR_W-1:0]             xlat_pa,
    input  logic                          xlat_exc,
    input  logic [5:0]                    xlat_ecode,
    input  logic                          flush,
    input  logic [ADDR_W-1:0]             flush_pc,
    input  logic                          br_taken,
    input  logic [ADDR_W-1:0]             br_target,
    input  logic                          br_stall,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [32+ADDR_W+1+6+9+ADDR_W-1:0] out_bus
);

    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc;
    logic              halted;
    logic [CW-1:0]     outst_cnt, discard_cnt, live_cnt;

    logic              redirect, fetch_ok, fetch_exc, issue, exc_alloc, drop, fill, pop;
    logic [ADDR_W-1:0] redirect_pc;
    logic [5:0]        fetch_ecode;
    logic              head_done, head_exc;
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       head_inst;
    logic [5:0]        head_ecode;

    assign redirect    = flush | br_taken;
    assign redirect_pc = flush ? flush_pc : br_target;

    // Misalignment is detected locally and outranks the MMU fault.
    assign fetch_exc   = (fetch_pc[1:0] != 2'b00) | xlat_exc;
    assign fetch_ecode = (fetch_pc[1:0] != 2'b00) ? ECODE_ADEF : xlat_ecode;

    assign fetch_ok  = resetn & ~halted & ~br_stall & ~redirect & (live_cnt < CW'(DEPTH));
    assign inst_req  = fetch_ok & ~fetch_exc & (outst_cnt < CW'(MAX_OUTST));
    assign exc_alloc = fetch_ok & fetch_exc;
    assign issue     = inst_req & inst_addr_ok;
    assign drop      = inst_data_ok & (discard_cnt != '0);
    assign fill      = inst_data_ok & ~drop;
    assign pop       = out_valid & out_ready;

    assign inst_addr = xlat_pa;
    assign xlat_va   = fetch_pc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            halted      <= 1'b0;
            outst_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            outst_cnt <= outst_cnt + CW'(issue) - CW'(inst_data_ok);
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc    <= redirect_pc;
                halted      <= 1'b0;
                discard_cnt <= outst_cnt - CW'(inst_data_ok);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + ADDR_W'(32'd4);
                if (exc_alloc)
                    halted <= 1'b1;
                if (drop)
                    discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

    ifu_entry_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (redirect),
        .alloc       (issue | exc_alloc),
        .alloc_pc    (fetch_pc),
        .alloc_exc   (exc_alloc),
        .alloc_ecode (fetch_ecode),
        .fill        (fill),
        .fill_inst   (inst_rdata),
        .pop         (pop),
        .head_done   (head_done),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_exc    (head_exc),
        .head_ecode  (head_ecode),
        .live_cnt    (live_cnt)
    );

    assign out_valid = head_done;
    assign out_bus   = {head_inst, head_pc, head_exc, head_ecode, ESUBCODE_NONE,
                        head_exc ? head_pc : {ADDR_W{1'b0}}};

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run scored against an expected in-order PC stream.
module tb_ifu_prefetch_queue;
    import ifu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        resetn, inst_addr_ok, inst_data_ok, xlat_exc;
    logic        flush, br_taken, br_stall, out_ready;
    logic [31:0] inst_rdata, flush_pc, br_target, xlat_pa;
    logic [5:0]  xlat_ecode;
    logic        inst_req, out_valid;
    logic [31:0] inst_addr, xlat_va;
    logic [IF_BUS_W-1:0] out_bus;

    always #5 clk = ~clk;
    assign xlat_pa = xlat_va;

    ifu_prefetch_queue dut (
        .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .xlat_va(xlat_va), .xlat_pa(xlat_pa), .xlat_exc(xlat_exc), .xlat_ecode(xlat_ecode),
        .flush(flush), .flush_pc(flush_pc), .br_taken(br_taken), .br_target(br_target),
        .br_stall(br_stall), .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        want_data;
    logic [31:0] pend[$];
    logic        s_req, s_acc, s_valid, s_pop, s_dok, s_redir;
    logic [31:0] s_addr, s_va;
    if_bus_t     s_bus;

    typedef struct {
        logic        aok;
        logic        dok;
        logic        ordy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = RESET_PC + ($urandom_range(0, 63) << 2);
        if ($urandom_range(0, 7) == 0) t = t + 32'd2;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge with inputs already set; samples, then steps one clock.
    task automatic cycle();
        if (want_data && pend.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(pend.pop_front());
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
        end
        #1;
        s_req   = inst_req;
        s_addr  = inst_addr;
        s_acc   = inst_req & inst_addr_ok;
        s_valid = out_valid;
        s_pop   = out_valid & out_ready;
        s_bus   = if_bus_t'(out_bus);
        s_dok   = inst_data_ok;
        s_va    = xlat_va;
        s_redir = flush | br_taken;
        @(posedge clk);
        if (s_acc) pend.push_back(s_addr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; inst_addr_ok = 1'b0; want_data = 1'b0; xlat_exc = 1'b0;
        xlat_ecode = 6'h0; flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
        out_ready = 1'b0; flush_pc = 32'h0; br_target = 32'h0;
        pend.delete();
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    initial begin
        int acc_cnt, dok_cnt, pops;
        logic seen, blocked, p_req, p_acc, p_redir;
        logic [31:0] exp_pc, p_addr;
        int outst_m;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c000004, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c000008, 1'b1, 32'h1c000000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000004};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000010, 1'b1, 32'h1c000008};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000010, 1'b1, 32'h1c00000c};

        @(negedge clk);
        do_reset();
        check("reset_req", s_req, 0);
        check("reset_valid", s_valid, 0);
        check("reset_va", s_va, RESET_PC);

        // Back-to-back streaming, then addr_ok held low.
        for (int i = 0; i < 6; i++) begin
            inst_addr_ok = vecs[i].aok;
            want_data    = vecs[i].dok;
            out_ready    = vecs[i].ordy;
            cycle();
            check($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), s_bus.pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_inst", i), s_bus.inst, mem_word(vecs[i].exp_pc));
            end
        end

        // Full queue blocks issue; one pop frees exactly one slot.
        do_reset();
        inst_addr_ok = 1'b1; want_data = 1'b1; out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin cycle(); acc_cnt += int'(s_acc); end
        check("full_accepts", acc_cnt, 4);
        check("full_req_low", s_req, 0);
        check("full_valid", s_valid, 1);
        out_ready = 1'b1;
        cycle();
        check("full_pop", s_pop, 1);
        check("full_pop_pc", s_bus.pc, RESET_PC);
        out_ready = 1'b0;
        cycle();
        check("pop_then_issue", s_acc, 1);
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin cycle(); acc_cnt += int'(s_acc); end
        check("full_again", acc_cnt, 0);

        // Branch with two requests in flight: both responses are dropped.
        do_reset();
        inst_addr_ok = 1'b1;
        cycle();
        cycle();
        br_taken = 1'b1; br_target = 32'h1c000100;
        cycle();
        check("br_cycle_no_req", s_req, 0);
        br_taken = 1'b0; want_data = 1'b1; out_ready = 1'b1;
        dok_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (s_pop) begin
                seen = 1'b1;
                check("br_first_pc", s_bus.pc, 32'h1c000100);
                check("br_first_inst", s_bus.inst, mem_word(32'h1c000100));
            end else begin
                dok_cnt += int'(s_dok);
            end
        end
        check("br_pop_seen", seen, 1);
        check("br_dok_before_pop", dok_cnt, 3);

        // flush and br_taken together: flush target wins, request at t+1.
        do_reset();
        inst_addr_ok = 1'b0;
        cycle();
        check("stall_req", s_req, 1);
        flush = 1'b1; flush_pc = 32'h1c000200; br_taken = 1'b1; br_target = 32'h1c000300;
        cycle();
        check("both_no_req", s_req, 0);
        flush = 1'b0; br_taken = 1'b0; inst_addr_ok = 1'b1;
        cycle();
        check("both_req", s_req, 1);
        check("both_addr", s_addr, 32'h1c000200);

        // Misaligned target: one exception entry, then halted until a flush.
        do_reset();
        inst_addr_ok = 1'b1; want_data = 1'b1;
        br_taken = 1'b1; br_target = 32'h1c000102;
        cycle();
        br_taken = 1'b0; out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin cycle(); acc_cnt += int'(s_req); end
        check("adef_no_req", acc_cnt, 0);
        check("adef_valid", s_valid, 1);
        check("adef_exc", s_bus.exc_en, 1);
        check("adef_ecode", s_bus.ecode, ECODE_ADEF);
        check("adef_badv", s_bus.badv, 32'h1c000102);
        check("adef_pc", s_bus.pc, 32'h1c000102);
        check("adef_inst", s_bus.inst, 0);
        out_ready = 1'b1;
        cycle();
        check("adef_pop", s_pop, 1);
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin cycle(); acc_cnt += int'(s_req) + int'(s_valid); end
        check("adef_halted", acc_cnt, 0);
        flush = 1'b1; flush_pc = 32'h1c000040;
        cycle();
        flush = 1'b0;
        cycle();
        check("adef_resume_req", s_req, 1);
        check("adef_resume_addr", s_addr, 32'h1c000040);

        // Reset in the middle of a burst.
        do_reset();
        inst_addr_ok = 1'b1;
        cycle();
        cycle();
        want_data = 1'b1;
        cycle();
        want_data = 1'b0;
        cycle();
        check("mid_valid_before", s_valid, 1);
        resetn = 1'b0;
        cycle();
        check("mid_req_in_reset", s_req, 0);
        cycle();
        check("mid_valid_reset", s_valid, 0);
        check("mid_va_reset", s_va, RESET_PC);
        pend.delete();
        resetn = 1'b1;
        cycle();
        check("mid_restart_addr", s_addr, RESET_PC);
        check("mid_restart_req", s_req, 1);

        // Randomized run against the expected sequential PC stream.
        do_reset();
        exp_pc = RESET_PC; blocked = 1'b0; outst_m = 0; pops = 0;
        p_req = 1'b0; p_acc = 1'b0; p_redir = 1'b0; p_addr = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            inst_addr_ok = ($urandom_range(0, 3) != 0);
            want_data    = ($urandom_range(0, 2) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            br_stall     = ($urandom_range(0, 7) == 0);
            r            = $urandom_range(0, 23);
            flush        = (r == 0);
            br_taken     = (r <= 2);
            flush_pc     = rand_target();
            br_target    = rand_target();
            cycle();
            outst_m += int'(s_acc) - int'(s_dok);
            if (outst_m > MAX_OUTST) check("rnd_outst_bound", outst_m, MAX_OUTST);
            if (p_req && !p_acc && !p_redir && s_req) check("rnd_addr_stable", s_addr, p_addr);
            if (s_pop) begin
                pops++;
                if (blocked) check("rnd_pop_after_exc", 1, 0);
                check("rnd_pc", s_bus.pc, exp_pc);
                if (exp_pc[1:0] != 2'b00) begin
                    check("rnd_exc_en", s_bus.exc_en, 1);
                    check("rnd_ecode", s_bus.ecode, ECODE_ADEF);
                    check("rnd_badv", s_bus.badv, exp_pc);
                    blocked = 1'b1;
                end else begin
                    check("rnd_exc_clear", s_bus.exc_en, 0);
                    check("rnd_inst", s_bus.inst, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (s_redir) begin
                exp_pc  = flush ? flush_pc : br_target;
                blocked = 1'b0;
            end
            p_req = s_req; p_acc = s_acc; p_redir = s_redir; p_addr = s_addr;
        end
        check("rnd_progress", pops > 200, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
